// File: rtl/assoc_score_argmax_pkg.sv
// Shared definitions for the associative-memory score/argmax stage:
// FSM state encoding, hypervector geometry and a constant-width helper.
package assoc_score_argmax_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int HV_DIM  = 8192;
    localparam int CHUNK_W = 512;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/assoc_score_argmax.sv
// Accumulates per-chunk popcounts into one score per class and tracks the
// best-scoring class over a query; result held until the next start.
module assoc_score_argmax
    import assoc_score_argmax_pkg::*;
#(
    parameter int CHUNK_SUM_W      = 10,
    parameter int CHUNKS_PER_CLASS = HV_DIM / CHUNK_W,
    parameter int NUM_CLASSES      = 26,
    parameter int ACC_W            = CHUNK_SUM_W + clog2(CHUNKS_PER_CLASS),
    parameter int IDX_W            = clog2(NUM_CLASSES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sum_valid,
    input  logic [CHUNK_SUM_W-1:0] sum_in,
    output logic                   sum_ready,
    output logic                   result_valid,
    output logic [IDX_W-1:0]       best_idx,
    output logic [ACC_W-1:0]       best_score
);

    localparam int CNT_W = (clog2(CHUNKS_PER_CLASS) > 0) ? clog2(CHUNKS_PER_CLASS) : 1;

    localparam logic [CNT_W-1:0] CHUNK_LAST = CNT_W'(CHUNKS_PER_CLASS - 1);
    localparam logic [IDX_W-1:0] CLASS_LAST = IDX_W'(NUM_CLASSES - 1);

    state_t             state_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   chunk_cnt_reg;
    logic [IDX_W-1:0]   class_cnt_reg;
    logic [IDX_W-1:0]   best_idx_reg;
    logic [ACC_W-1:0]   best_score_reg;
    logic               sum_ready_reg;
    logic               result_valid_reg;

    logic [ACC_W-1:0]   sum_ext;
    logic               beat_ok;

    assign sum_ext = ACC_W'(sum_in);
    // sum_ready_reg is high exactly while in ACCUM, so it doubles as the accept qualifier.
    assign beat_ok = sum_valid & sum_ready_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            acc_reg          <= '0;
            chunk_cnt_reg    <= '0;
            class_cnt_reg    <= '0;
            best_idx_reg     <= '0;
            best_score_reg   <= '0;
            sum_ready_reg    <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        acc_reg          <= '0;
                        chunk_cnt_reg    <= '0;
                        class_cnt_reg    <= '0;
                        best_idx_reg     <= '0;
                        best_score_reg   <= '0;
                        sum_ready_reg    <= 1'b1;
                        result_valid_reg <= 1'b0;
                        state_reg        <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (beat_ok) begin
                        // First chunk of a class overwrites, so no separate clear cycle is needed.
                        if (chunk_cnt_reg == '0) begin
                            acc_reg <= sum_ext;
                        end else begin
                            acc_reg <= acc_reg + sum_ext;
                        end
                        if (chunk_cnt_reg == CHUNK_LAST) begin
                            chunk_cnt_reg <= '0;
                            sum_ready_reg <= 1'b0;
                            state_reg     <= COMPARE;
                        end else begin
                            chunk_cnt_reg <= chunk_cnt_reg + CNT_W'(1);
                        end
                    end
                end

                COMPARE: begin
                    // Strict greater-than keeps the lowest index on ties.
                    if ((class_cnt_reg == '0) || (acc_reg > best_score_reg)) begin
                        best_score_reg <= acc_reg;
                        best_idx_reg   <= class_cnt_reg;
                    end
                    if (class_cnt_reg == CLASS_LAST) begin
                        result_valid_reg <= 1'b1;
                        state_reg        <= DONE;
                    end else begin
                        class_cnt_reg <= class_cnt_reg + IDX_W'(1);
                        sum_ready_reg <= 1'b1;
                        state_reg     <= ACCUM;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sum_ready    = sum_ready_reg;
    assign result_valid = result_valid_reg;
    assign best_idx     = best_idx_reg;
    assign best_score   = best_score_reg;

endmodule

// File: tb/tb_assoc_score_argmax.sv
// Directed bench for assoc_score_argmax with 4 classes of 16 chunks each;
// expected winners and scores are hand-computed per scenario.
module tb_assoc_score_argmax;

    localparam int CHUNK_SUM_W = 10;
    localparam int CHUNKS      = 16;
    localparam int CLASSES     = 4;
    localparam int ACC_W       = 14;
    localparam int IDX_W       = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic                   sum_valid;
    logic [CHUNK_SUM_W-1:0] sum_in;
    logic                   sum_ready;
    logic                   result_valid;
    logic [IDX_W-1:0]       best_idx;
    logic [ACC_W-1:0]       best_score;

    int total;
    int bad;
    int pattern [0:CLASSES-1][0:CHUNKS-1];

    assoc_score_argmax #(
        .CHUNK_SUM_W      (CHUNK_SUM_W),
        .CHUNKS_PER_CLASS (CHUNKS),
        .NUM_CLASSES      (CLASSES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sum_valid    (sum_valid),
        .sum_in       (sum_in),
        .sum_ready    (sum_ready),
        .result_valid (result_valid),
        .best_idx     (best_idx),
        .best_score   (best_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic set_const(input int v0, input int v1, input int v2, input int v3);
        for (int k = 0; k < CHUNKS; k++) begin
            pattern[0][k] = v0;
            pattern[1][k] = v1;
            pattern[2][k] = v2;
            pattern[3][k] = v3;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_ready", 32'(sum_ready), 32'd1);
    endtask

    // Streams pattern beats; stops after stop_after accepted beats.
    task automatic send_beats(input bit gaps, input int stop_after, input string tag);
        int beats;
        int guard;
        beats = 0;
        guard = 0;
        while (beats < stop_after && guard < 3000) begin
            sum_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            sum_in    = CHUNK_SUM_W'(pattern[beats / CHUNKS][beats % CHUNKS]);
            @(negedge clk);
            if (sum_valid && sum_ready) begin
                beats++;
                tick();
                if (beats % CHUNKS == 0) begin
                    check_eq({tag, "_cmp_ready"}, 32'(sum_ready), 32'd0);
                    if (beats == CLASSES * CHUNKS) begin
                        check_eq({tag, "_rv_lat1"}, 32'(result_valid), 32'd0);
                    end
                end
            end else begin
                tick();
            end
            guard++;
        end
        sum_valid = 1'b0;
        if (beats < stop_after) begin
            check_eq({tag, "_timeout"}, 32'(beats), 32'(stop_after));
        end
    endtask

    task automatic run_query(input bit gaps, input string tag, input int exp_idx, input int exp_score);
        send_beats(gaps, CLASSES * CHUNKS, tag);
        tick();
        check_eq({tag, "_rv_lat2"}, 32'(result_valid), 32'd1);
        check_eq({tag, "_idx"}, 32'(best_idx), 32'(exp_idx));
        check_eq({tag, "_score"}, 32'(best_score), 32'(exp_score));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        sum_valid = 1'b0;
        sum_in    = '0;

        tick();
        tick();
        check_eq("rst_ready", 32'(sum_ready), 32'd0);
        check_eq("rst_rv", 32'(result_valid), 32'd0);
        check_eq("rst_idx", 32'(best_idx), 32'd0);
        check_eq("rst_score", 32'(best_score), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_ready", 32'(sum_ready), 32'd0);

        // Basic argmax: sums 160, 480, 320, 80.
        set_const(10, 30, 20, 5);
        pulse_start();
        run_query(1'b0, "basic", 1, 480);
        tick();
        tick();
        check_eq("done_hold_rv", 32'(result_valid), 32'd1);
        check_eq("done_hold_score", 32'(best_score), 32'd480);

        // All-max tie: every class 8192, lowest index wins.
        set_const(512, 512, 512, 512);
        pulse_start();
        run_query(1'b0, "tie_max", 0, 8192);

        // Random gaps: chunk k of class c is base[c]+k -> 440, 760, 200, 760.
        for (int k = 0; k < CHUNKS; k++) begin
            pattern[0][k] = 20 + k;
            pattern[1][k] = 40 + k;
            pattern[2][k] = 5 + k;
            pattern[3][k] = 40 + k;
        end
        pulse_start();
        run_query(1'b1, "gaps", 1, 760);

        // Reset during class 2 chunk 7 with large partial data.
        set_const(511, 511, 511, 511);
        pulse_start();
        send_beats(1'b0, 2 * CHUNKS + 7, "partial");
        rst_n = 1'b0;
        tick();
        check_eq("midrst_ready", 32'(sum_ready), 32'd0);
        check_eq("midrst_rv", 32'(result_valid), 32'd0);
        check_eq("midrst_idx", 32'(best_idx), 32'd0);
        check_eq("midrst_score", 32'(best_score), 32'd0);
        rst_n = 1'b1;
        tick();
        set_const(100, 50, 200, 150);
        pulse_start();
        run_query(1'b0, "after_rst", 2, 3200);

        // Restart straight out of DONE.
        set_const(3, 3, 9, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart_rv", 32'(result_valid), 32'd0);
        check_eq("restart_ready", 32'(sum_ready), 32'd1);
        run_query(1'b0, "restart", 2, 144);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
